// File: rtl/column_move_collector.sv
// Per-column move collector: picks the best MVV-LVA request from the column's rows
// each cycle and queues the winners in a show-ahead FIFO toward the control unit.
module column_move_collector #(
    parameter  int ROWS  = 8,
    parameter  int SQW   = 6,
    parameter  int PCW   = 3,
    parameter  int DEPTH = 16,
    localparam int MW    = 2*SQW + 2*PCW
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 newboard,
    input  logic [ROWS-1:0]      row_req,
    input  logic [ROWS*MW-1:0]   row_move,
    input  logic [ROWS-1:0]      row_done,
    output logic [ROWS-1:0]      row_gnt,
    output logic                 m_valid,
    output logic [MW-1:0]        m_data,
    output logic [2*PCW-1:0]     m_score,
    input  logic                 m_ready,
    output logic [7:0]           move_cnt,
    output logic                 busy,
    output logic                 done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int IW = $clog2(ROWS);
    localparam int SW = 2*PCW;

    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;

    state_t          r_state;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [7:0]      r_move_cnt;
    logic            r_busy;
    logic            r_done;
    logic [MW-1:0]   r_mem [DEPTH];

    logic [SW-1:0]   w_best_score;
    logic [IW-1:0]   w_best_idx;
    logic            w_any_req;
    logic [MW-1:0]   w_sel_move;
    logic            w_full;
    logic            w_pop;
    logic            w_push;
    state_t          w_state_nxt;

    // Captures of richer victims rank higher; cheaper attackers break ties via ~attacker.
    function automatic logic [SW-1:0] score_of(input logic [MW-1:0] mv);
        return {mv[PCW-1:0], ~mv[2*PCW-1:PCW]};
    endfunction

    // Strict '>' keeps the lowest-index row on equal scores.
    always_comb begin
        w_best_score = '0;
        w_best_idx   = '0;
        w_any_req    = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            if (row_req[r] && (!w_any_req || score_of(row_move[r*MW +: MW]) > w_best_score)) begin
                w_best_score = score_of(row_move[r*MW +: MW]);
                w_best_idx   = IW'(r);
                w_any_req    = 1'b1;
            end
        end
    end

    assign w_sel_move = row_move[w_best_idx*MW +: MW];
    assign w_full     = (r_count == CW'(DEPTH));
    assign m_valid    = (r_count != '0);
    assign w_pop      = m_valid && m_ready && !newboard;
    assign w_push     = !reset && !newboard && (r_state == COLLECT) && w_any_req
                        && (!w_full || w_pop);
    assign row_gnt    = w_push ? (ROWS'(1) << w_best_idx) : '0;

    assign m_data     = m_valid ? r_mem[r_rd_ptr] : '0;
    assign m_score    = m_valid ? score_of(r_mem[r_rd_ptr]) : '0;
    assign move_cnt   = r_move_cnt;
    assign busy       = r_busy;
    assign done       = r_done;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = IDLE;
            COLLECT: if (&row_done && !(|row_req)) w_state_nxt = DRAIN;
            DRAIN:   if (r_count == '0 || (r_count == CW'(1) && w_pop)) w_state_nxt = DONE;
            DONE:    w_state_nxt = DONE;
            default: w_state_nxt = IDLE;
        endcase
        if (newboard) w_state_nxt = COLLECT;
    end

    // Storage carries no reset; validity comes from r_count alone.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_sel_move;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_move_cnt <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == COLLECT) || (w_state_nxt == DRAIN);
            r_done  <= (w_state_nxt == DONE);
            if (newboard) begin
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_count    <= '0;
                r_move_cnt <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
                if (w_push && !w_pop)      r_count <= r_count + CW'(1);
                else if (!w_push && w_pop) r_count <= r_count - CW'(1);
                if (w_push && r_move_cnt != 8'hFF) r_move_cnt <= r_move_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_column_move_collector.sv
// Directed bench for column_move_collector: arbitration order, FIFO full/pop behaviour,
// drain/done sequencing and newboard/reset priority.
module tb_column_move_collector;

    localparam int ROWS = 8;
    localparam int SQW  = 6;
    localparam int PCW  = 3;
    localparam int MW   = 2*SQW + 2*PCW;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                newboard = 1'b0;
    logic [ROWS-1:0]     row_req = '0;
    logic [ROWS*MW-1:0]  row_move = '0;
    logic [ROWS-1:0]     row_done = '0;
    logic [ROWS-1:0]     row_gnt;
    logic                m_valid;
    logic [MW-1:0]       m_data;
    logic [2*PCW-1:0]    m_score;
    logic                m_ready = 1'b0;
    logic [7:0]          move_cnt;
    logic                busy;
    logic                done;

    int n_cmp = 0;
    int n_bad = 0;

    column_move_collector #(.ROWS(ROWS), .SQW(SQW), .PCW(PCW), .DEPTH(16)) dut (
        .clk(clk), .reset(reset), .newboard(newboard),
        .row_req(row_req), .row_move(row_move), .row_done(row_done), .row_gnt(row_gnt),
        .m_valid(m_valid), .m_data(m_data), .m_score(m_score), .m_ready(m_ready),
        .move_cnt(move_cnt), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [MW-1:0] mk(input int from, input int to, input int att, input int vic);
        logic [MW-1:0] m;
        m = {SQW'(from), SQW'(to), PCW'(att), PCW'(vic)};
        return m;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #2;
    endtask

    task automatic set_move(input int r, input logic [MW-1:0] m);
        row_move[r*MW +: MW] = m;
    endtask

    task automatic push_one(input int r, input logic [MW-1:0] m, input string tag);
        set_move(r, m);
        row_req = ROWS'(1) << r;
        settle;
        check_eq(tag, 32'(row_gnt), 32'(ROWS'(1) << r));
        step;
        row_req = '0;
    endtask

    logic [MW-1:0] mv2, mv5, mv1, mv6, qv, p0, p1, p2;

    initial begin
        #1;
        // reset for two cycles, then start a board
        step; step;
        reset = 1'b0;
        settle;
        check_eq("rst_m_valid", 32'(m_valid), 0);
        check_eq("rst_m_data", 32'(m_data), 0);
        check_eq("rst_m_score", 32'(m_score), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_gnt", 32'(row_gnt), 0);
        check_eq("rst_move_cnt", 32'(move_cnt), 0);
        newboard = 1'b1;
        step;
        newboard = 1'b0;
        check_eq("nb_busy", 32'(busy), 1);
        check_eq("nb_done", 32'(done), 0);

        // PAWNxROOK on row 2 beats QUEENxROOK on row 5
        mv2 = mk(8'o12, 8'o25, 1, 4);
        mv5 = mk(8'o52, 8'o25, 5, 4);
        set_move(2, mv2);
        set_move(5, mv5);
        row_req = 8'b0010_0100;
        m_ready = 1'b1;
        settle;
        check_eq("arb_gnt_row2", 32'(row_gnt), 32'h04);
        step;
        row_req = 8'b0010_0000;
        settle;
        check_eq("arb_gnt_row5", 32'(row_gnt), 32'h20);
        check_eq("arb_head_valid", 32'(m_valid), 1);
        check_eq("arb_head_row2", 32'(m_data), 32'(mv2));
        check_eq("arb_score_row2", 32'(m_score), 32'h26);
        step;
        row_req = '0;
        settle;
        check_eq("arb_head_row5", 32'(m_data), 32'(mv5));
        check_eq("arb_score_row5", 32'(m_score), 32'h22);
        check_eq("arb_move_cnt", 32'(move_cnt), 2);
        step;
        check_eq("arb_empty", 32'(m_valid), 0);

        // equal scores go to the lower row
        mv1 = mk(8'o11, 8'o33, 2, 3);
        mv6 = mk(8'o16, 8'o44, 2, 3);
        set_move(1, mv1);
        set_move(6, mv6);
        row_req = 8'b0100_0010;
        settle;
        check_eq("tie_gnt_row1", 32'(row_gnt), 32'h02);
        step;
        row_req = 8'b0100_0000;
        settle;
        check_eq("tie_gnt_row6", 32'(row_gnt), 32'h40);
        check_eq("tie_head_row1", 32'(m_data), 32'(mv1));
        step;
        row_req = '0;
        settle;
        check_eq("tie_head_row6", 32'(m_data), 32'(mv6));
        step; step;
        check_eq("tie_empty", 32'(m_valid), 0);

        // fill with quiet moves while the consumer stalls
        m_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            qv = (i < 16) ? mk(i, 63 - i, 2, 0) : mk(16, 47, 2, 0);
            set_move(3, qv);
            row_req = 8'b0000_1000;
            settle;
            check_eq($sformatf("full_gnt_%0d", i), 32'(row_gnt), (i < 16) ? 32'h08 : 32'h00);
            step;
        end
        check_eq("full_head", 32'(m_data), 32'(mk(0, 63, 2, 0)));
        check_eq("full_score", 32'(m_score), 32'h05);
        m_ready = 1'b1;
        settle;
        check_eq("full_pop_gnt", 32'(row_gnt), 32'h08);
        step;
        m_ready = 1'b0;
        set_move(3, mk(17, 46, 2, 0));
        settle;
        check_eq("full_still_full", 32'(row_gnt), 32'h00);
        check_eq("full_head_next", 32'(m_data), 32'(mk(1, 62, 2, 0)));
        check_eq("full_move_cnt", 32'(move_cnt), 21);
        row_req = '0;

        // drain three buffered moves to DONE
        newboard = 1'b1;
        step;
        newboard = 1'b0;
        check_eq("dr_flush_valid", 32'(m_valid), 0);
        check_eq("dr_flush_cnt", 32'(move_cnt), 0);
        p0 = mk(1, 2, 3, 4);
        p1 = mk(5, 6, 4, 2);
        p2 = mk(7, 8, 6, 0);
        push_one(0, p0, "dr_push0");
        push_one(0, p1, "dr_push1");
        push_one(0, p2, "dr_push2");
        row_done = '1;
        step;
        check_eq("dr_busy", 32'(busy), 1);
        check_eq("dr_head0", 32'(m_data), 32'(p0));
        m_ready = 1'b1;
        step;
        check_eq("dr_head1", 32'(m_data), 32'(p1));
        step;
        check_eq("dr_head2", 32'(m_data), 32'(p2));
        check_eq("dr_not_done", 32'(done), 0);
        step;
        check_eq("dr_done", 32'(done), 1);
        check_eq("dr_done_busy", 32'(busy), 0);
        check_eq("dr_done_empty", 32'(m_valid), 0);
        m_ready = 1'b0;

        // newboard while draining five moves
        newboard = 1'b1;
        row_done = '0;
        step;
        newboard = 1'b0;
        check_eq("nb2_busy", 32'(busy), 1);
        check_eq("nb2_done", 32'(done), 0);
        for (int i = 0; i < 5; i++) push_one(7, mk(i, i + 9, 5, 1), $sformatf("nb2_push%0d", i));
        row_done = '1;
        step;
        check_eq("nb2_drain_valid", 32'(m_valid), 1);
        check_eq("nb2_drain_cnt", 32'(move_cnt), 5);
        newboard = 1'b1;
        m_ready = 1'b1;
        step;
        newboard = 1'b0;
        m_ready = 1'b0;
        row_done = '0;
        check_eq("nb2_flush_valid", 32'(m_valid), 0);
        check_eq("nb2_flush_cnt", 32'(move_cnt), 0);
        check_eq("nb2_collect_busy", 32'(busy), 1);
        set_move(4, mk(3, 3, 1, 5));
        row_req = 8'b0001_0000;
        settle;
        check_eq("nb2_collect_gnt", 32'(row_gnt), 32'h10);

        // reset wins over newboard
        reset = 1'b1;
        newboard = 1'b1;
        step;
        reset = 1'b0;
        newboard = 1'b0;
        check_eq("rnb_busy", 32'(busy), 0);
        check_eq("rnb_done", 32'(done), 0);
        check_eq("rnb_valid", 32'(m_valid), 0);
        check_eq("rnb_cnt", 32'(move_cnt), 0);
        settle;
        check_eq("rnb_idle_gnt", 32'(row_gnt), 0);
        row_req = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
